// File: rtl/mem_arb.sv
// Two-port (CPU / debug) arbiter serialising accesses to a single memory as IDLE -> ACCESS -> RESP.
// Define ARB_ROUND_ROBIN_EN for round-robin tie-breaking; otherwise the CPU always wins ties.
module mem_arb #(
   parameter int unsigned AW = 5,
   parameter int unsigned DW = 8
) (
   input  logic          clk,
   input  logic          rst_,
   input  logic          cpu_req,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_wdata,
   output logic          cpu_ack,
   output logic [DW-1:0] cpu_rdata,
   input  logic          dbg_req,
   input  logic          dbg_we,
   input  logic [AW-1:0] dbg_addr,
   input  logic [DW-1:0] dbg_wdata,
   output logic          dbg_ack,
   output logic [DW-1:0] dbg_rdata,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   output logic          mem_rd,
   output logic          mem_wr,
   output logic          owner,
   output logic          busy
);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   state_t state, state_d;
   logic   grant;
   logic   grant_dbg;

`ifdef ARB_ROUND_ROBIN_EN
   logic   last_dbg;
`endif

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) state <= IDLE;
      else       state <= state_d;
   end

   always_comb begin
      state_d   = state;
      grant     = 1'b0;
      grant_dbg = 1'b0;
      unique case (state)
         IDLE: begin
            if (cpu_req || dbg_req) begin
               grant   = 1'b1;
               state_d = ACCESS;
`ifdef ARB_ROUND_ROBIN_EN
               grant_dbg = dbg_req && (!cpu_req || !last_dbg);
`else
               grant_dbg = dbg_req && !cpu_req;
`endif
            end
         end
         ACCESS:  state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // mem_addr/mem_wdata double as the latched request fields; mem_rd marks a read in ACCESS.
   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         mem_rd    <= 1'b0;
         mem_wr    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         cpu_ack   <= 1'b0;
         dbg_ack   <= 1'b0;
         cpu_rdata <= '0;
         dbg_rdata <= '0;
         owner     <= 1'b0;
         busy      <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
         last_dbg  <= 1'b1;
`endif
      end else begin
         mem_rd  <= 1'b0;
         mem_wr  <= 1'b0;
         cpu_ack <= 1'b0;
         dbg_ack <= 1'b0;
         busy    <= (state_d != IDLE);
         if (grant) begin
            owner     <= grant_dbg;
            mem_addr  <= grant_dbg ? dbg_addr  : cpu_addr;
            mem_wdata <= grant_dbg ? dbg_wdata : cpu_wdata;
            mem_rd    <= grant_dbg ? !dbg_we   : !cpu_we;
            mem_wr    <= grant_dbg ? dbg_we    : cpu_we;
`ifdef ARB_ROUND_ROBIN_EN
            last_dbg  <= grant_dbg;
`endif
         end
         if (state == ACCESS) begin
            if (owner) begin
               dbg_ack <= 1'b1;
               if (mem_rd) dbg_rdata <= mem_rdata;
            end else begin
               cpu_ack <= 1'b1;
               if (mem_rd) cpu_rdata <= mem_rdata;
            end
         end
      end
   end

endmodule

// File: tb/tb_mem_arb.sv
// Self-checking bench for mem_arb: vector table, directed corner cases, and a
// randomized run against a transaction-level reference model.
module tb_mem_arb;
   logic       clk = 1'b0;
   logic       rst_;
   logic       cpu_req, cpu_we, cpu_ack;
   logic [4:0] cpu_addr;
   logic [7:0] cpu_wdata, cpu_rdata;
   logic       dbg_req, dbg_we, dbg_ack;
   logic [4:0] dbg_addr;
   logic [7:0] dbg_wdata, dbg_rdata;
   logic [4:0] mem_addr;
   logic [7:0] mem_wdata, mem_rdata;
   logic       mem_rd, mem_wr, owner, busy;

   int checks = 0;
   int failures = 0;

   logic [7:0] mem [32];
   logic [7:0] ref_mem [32];
   logic       pre_we;
   logic [4:0] pre_addr;
   logic [7:0] pre_data;
   logic [7:0] exp_rdat [2];
   bit         exp_last;

   typedef struct {
      bit         port;
      bit         we;
      logic [4:0] addr;
      logic [7:0] wdata;
      logic [7:0] rdata;
   } vec_t;
   vec_t vt [8];

   mem_arb #(.AW(5), .DW(8)) dut (
      .clk(clk), .rst_(rst_),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
      .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
      .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .mem_rd(mem_rd), .mem_wr(mem_wr), .owner(owner), .busy(busy)
   );

   always #5 clk = ~clk;

   assign mem_rdata = mem[mem_addr];
   always @(posedge clk) begin
      if (mem_wr)      mem[mem_addr] <= mem_wdata;
      else if (pre_we) mem[pre_addr] <= pre_data;
   end

   a_strobe_excl: assert property (@(posedge clk) !(mem_rd && mem_wr));

   task automatic chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input bit port, input bit req, input bit we,
                        input logic [4:0] a, input logic [7:0] d);
      if (port) begin
         dbg_req = req; dbg_we = we; dbg_addr = a; dbg_wdata = d;
      end else begin
         cpu_req = req; cpu_we = we; cpu_addr = a; cpu_wdata = d;
      end
   endtask

   task automatic preload(input logic [4:0] a, input logic [7:0] d);
      pre_we = 1'b1; pre_addr = a; pre_data = d;
      ref_mem[a] = d;
      @(negedge clk);
      pre_we = 1'b0;
   endtask

   // Single uncontended transaction; called and returns just after a falling edge.
   task automatic do_txn(input string name, input bit port, input bit we,
                         input logic [4:0] a, input logic [7:0] d, input logic [7:0] exp_rd);
      drive(port, 1'b1, we, a, d);
      @(negedge clk);
      chk1({name, "_rd"}, mem_rd, !we);
      chk1({name, "_wr"}, mem_wr, we);
      chk8({name, "_addr"}, 8'(mem_addr), 8'(a));
      if (we) chk8({name, "_wdata"}, mem_wdata, d);
      chk1({name, "_owner"}, owner, port);
      chk1({name, "_busy_acc"}, busy, 1'b1);
      chk1({name, "_noack_acc"}, cpu_ack | dbg_ack, 1'b0);
      @(negedge clk);
      chk1({name, "_strobe_off"}, mem_rd | mem_wr, 1'b0);
      chk1({name, "_cpu_ack"}, cpu_ack, !port);
      chk1({name, "_dbg_ack"}, dbg_ack, port);
      chk1({name, "_busy_resp"}, busy, 1'b1);
      if (we) ref_mem[a] = d;
      else    exp_rdat[port] = exp_rd;
      chk8({name, "_cpu_rdata"}, cpu_rdata, exp_rdat[0]);
      chk8({name, "_dbg_rdata"}, dbg_rdata, exp_rdat[1]);
      drive(port, 1'b0, 1'b0, '0, '0);
      @(negedge clk);
      chk1({name, "_ack_clear"}, cpu_ack | dbg_ack, 1'b0);
      chk1({name, "_idle"}, busy, 1'b0);
      exp_last = port;
   endtask

   initial begin
      bit expw;
      rst_ = 1'b0;
      pre_we = 1'b0; pre_addr = '0; pre_data = '0;
      drive(1'b0, 1'b0, 1'b0, '0, '0);
      drive(1'b1, 1'b0, 1'b0, '0, '0);
      exp_rdat[0] = '0; exp_rdat[1] = '0; exp_last = 1'b1;
      for (int i = 0; i < 32; i++) preload(5'(i), 8'($urandom));

      // reset state
      chk1("rst_mem_rd", mem_rd, 1'b0);
      chk1("rst_mem_wr", mem_wr, 1'b0);
      chk1("rst_cpu_ack", cpu_ack, 1'b0);
      chk1("rst_dbg_ack", dbg_ack, 1'b0);
      chk1("rst_busy", busy, 1'b0);
      chk1("rst_owner", owner, 1'b0);
      chk8("rst_mem_addr", 8'(mem_addr), 8'h00);
      chk8("rst_mem_wdata", mem_wdata, 8'h00);
      chk8("rst_cpu_rdata", cpu_rdata, 8'h00);
      chk8("rst_dbg_rdata", dbg_rdata, 8'h00);
      rst_ = 1'b1;
      @(negedge clk);
      chk1("post_rst_idle", busy, 1'b0);

      preload(5'h1F, 8'h3C);
      vt[0] = '{1'b1, 1'b1, 5'h03, 8'hA5, 8'h00};
      vt[1] = '{1'b1, 1'b0, 5'h03, 8'h00, 8'hA5};
      vt[2] = '{1'b0, 1'b0, 5'h1F, 8'h00, 8'h3C};
      vt[3] = '{1'b0, 1'b1, 5'h10, 8'h5A, 8'h00};
      vt[4] = '{1'b1, 1'b0, 5'h10, 8'h00, 8'h5A};
      vt[5] = '{1'b0, 1'b0, 5'h03, 8'h00, 8'hA5};
      vt[6] = '{1'b0, 1'b1, 5'h00, 8'hFF, 8'h00};
      vt[7] = '{1'b1, 1'b0, 5'h00, 8'h00, 8'hFF};
      for (int i = 0; i < 8; i++)
         do_txn($sformatf("vec%0d", i), vt[i].port, vt[i].we, vt[i].addr, vt[i].wdata, vt[i].rdata);

      // both requesters held high continuously
      preload(5'h01, 8'h11);
      preload(5'h02, 8'h22);
      drive(1'b0, 1'b1, 1'b0, 5'h01, 8'h00);
      drive(1'b1, 1'b1, 1'b0, 5'h02, 8'h00);
      expw = 1'b0;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         if (k % 3 == 0) begin
`ifdef ARB_ROUND_ROBIN_EN
            expw = !exp_last;
`else
            expw = 1'b0;
`endif
            chk1("tie_strobe", mem_rd, 1'b1);
            chk1("tie_owner", owner, expw);
            exp_last = expw;
         end
         if (k % 3 == 1) begin
            chk1("tie_cpu_ack", cpu_ack, !expw);
            chk1("tie_dbg_ack", dbg_ack, expw);
            exp_rdat[expw] = expw ? 8'h22 : 8'h11;
            chk8("tie_rdata", expw ? dbg_rdata : cpu_rdata, exp_rdat[expw]);
         end else begin
            chk1("tie_no_ack", cpu_ack | dbg_ack, 1'b0);
         end
      end
      drive(1'b0, 1'b0, 1'b0, '0, '0);
      @(negedge clk);
      chk1("tie_dbg_grant", mem_rd, 1'b1);
      chk1("tie_dbg_owner", owner, 1'b1);
      @(negedge clk);
      chk1("tie_dbg_final_ack", dbg_ack, 1'b1);
      chk8("tie_dbg_final_rdata", dbg_rdata, 8'h22);
      exp_rdat[1] = 8'h22; exp_last = 1'b1;
      drive(1'b1, 1'b0, 1'b0, '0, '0);
      @(negedge clk);
      chk1("tie_idle", busy, 1'b0);

      // reset during ACCESS of a CPU write
      preload(5'h0A, 8'h11);
      drive(1'b0, 1'b1, 1'b1, 5'h0A, 8'h77);
      @(negedge clk);
      chk1("rstw_wr_before", mem_wr, 1'b1);
      #2 rst_ = 1'b0;
      #1;
      chk1("rstw_wr_drop", mem_wr, 1'b0);
      chk1("rstw_busy_drop", busy, 1'b0);
      chk1("rstw_owner", owner, 1'b0);
      drive(1'b0, 1'b0, 1'b0, '0, '0);
      @(negedge clk);
      chk1("rstw_no_ack", cpu_ack, 1'b0);
      rst_ = 1'b1;
      exp_rdat[0] = '0; exp_rdat[1] = '0; exp_last = 1'b1;
      @(negedge clk);
      chk1("rstw_idle", busy | mem_rd | mem_wr | cpu_ack, 1'b0);
      chk8("rstw_rdata_clr", dbg_rdata, 8'h00);
      do_txn("rstw_reissue", 1'b0, 1'b1, 5'h0A, 8'h77, 8'h00);
      do_txn("rstw_readback", 1'b1, 1'b0, 5'h0A, 8'h00, 8'h77);

      // address change after grant must not affect the access
      preload(5'h04, 8'h44);
      preload(5'h09, 8'h99);
      drive(1'b1, 1'b1, 1'b0, 5'h04, 8'h00);
      @(negedge clk);
      chk8("chg_addr_grant", 8'(mem_addr), 8'h04);
      dbg_addr = 5'h09;
      @(negedge clk);
      chk8("chg_addr_held", 8'(mem_addr), 8'h04);
      chk1("chg_ack", dbg_ack, 1'b1);
      chk8("chg_rdata", dbg_rdata, 8'h44);
      drive(1'b1, 1'b0, 1'b0, '0, '0);
      @(negedge clk);

      // randomized traffic against a transaction-level model
      rst_ = 1'b0;
      @(negedge clk);
      rst_ = 1'b1;
      exp_rdat[0] = '0; exp_rdat[1] = '0;
      begin
         bit         p_pend [2];
         bit         p_we [2];
         logic [4:0] p_addr [2];
         logic [7:0] p_wd [2];
         bit         just_acked [2];
         int         g_edge;
         bit         g_port, g_we, exp_owner, last_dbg;
         logic [4:0] g_addr;
         logic [7:0] g_wd;
         g_edge = -100; g_port = 1'b0; g_we = 1'b0; g_addr = '0; g_wd = '0;
         exp_owner = 1'b0; last_dbg = 1'b1;
         for (int p = 0; p < 2; p++) begin
            p_pend[p] = 1'b0; p_we[p] = 1'b0; p_addr[p] = '0; p_wd[p] = '0; just_acked[p] = 1'b0;
         end
         for (int e = 0; e < 3000; e++) begin
            for (int p = 0; p < 2; p++) begin
               if (!p_pend[p] && !just_acked[p] && $urandom_range(0, 3) == 0) begin
                  p_pend[p] = 1'b1;
                  p_we[p]   = 1'($urandom);
                  p_addr[p] = 5'($urandom);
                  p_wd[p]   = 8'($urandom);
               end
               just_acked[p] = 1'b0;
               drive(1'(p), p_pend[p], p_we[p], p_addr[p], p_wd[p]);
            end
            if (e >= g_edge + 3 && (p_pend[0] || p_pend[1])) begin
`ifdef ARB_ROUND_ROBIN_EN
               if (p_pend[0] && p_pend[1]) g_port = !last_dbg;
`else
               if (p_pend[0] && p_pend[1]) g_port = 1'b0;
`endif
               else g_port = p_pend[1];
               last_dbg = g_port;
               exp_owner = g_port;
               g_edge = e;
               g_we = p_we[g_port]; g_addr = p_addr[g_port]; g_wd = p_wd[g_port];
            end
            @(negedge clk);
            if (e == g_edge + 1) begin
               if (g_we) ref_mem[g_addr] = g_wd;
               else      exp_rdat[g_port] = ref_mem[g_addr];
               p_pend[g_port] = 1'b0;
               just_acked[g_port] = 1'b1;
            end
            chk1("rnd_mem_rd", mem_rd, (e == g_edge) && !g_we);
            chk1("rnd_mem_wr", mem_wr, (e == g_edge) && g_we);
            chk1("rnd_busy", busy, (e == g_edge) || (e == g_edge + 1));
            chk1("rnd_cpu_ack", cpu_ack, (e == g_edge + 1) && !g_port);
            chk1("rnd_dbg_ack", dbg_ack, (e == g_edge + 1) && g_port);
            chk1("rnd_owner", owner, exp_owner);
            chk8("rnd_cpu_rdata", cpu_rdata, exp_rdat[0]);
            chk8("rnd_dbg_rdata", dbg_rdata, exp_rdat[1]);
            if (e == g_edge) begin
               chk8("rnd_mem_addr", 8'(mem_addr), 8'(g_addr));
               chk8("rnd_mem_wdata", mem_wdata, g_wd);
            end
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mem_arb.md
# mem_arb

Two-port arbiter that shares the single 32x8 memory between the CPU's fetch/execute path and a debug/loader port. It sits between the requesters and memory. It serialises every access into a fixed three-state transaction, drives exactly one memory strobe at a time, and returns a one-cycle acknowledge with registered read data. It lets a host load programs into memory or inspect it without a second memory port.

## Interface
- AW, 5, address width (memory depth 2^AW)
- DW, 8, data width
- clk  in  1  system clock, rising edge
- rst_  in  1  asynchronous, active-low reset
- cpu_req  in  1  CPU access request; held until cpu_ack
- cpu_we  in  1  1 = write, 0 = read; stable while cpu_req high
- cpu_addr  in  AW  CPU address
- cpu_wdata  in  DW  CPU write data
- cpu_ack  out  1  one-cycle completion pulse to CPU
- cpu_rdata  out  DW  read data, valid while cpu_ack high
- dbg_req, dbg_we, dbg_addr, dbg_wdata  in  1/1/AW/DW  debug port, same rules as CPU
- dbg_ack  out  1  one-cycle completion pulse to debug port
- dbg_rdata  out  DW  read data, valid while dbg_ack high
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data (combinational from mem_addr)
- mem_rd  out  1  memory read strobe
- mem_wr  out  1  memory write strobe
- owner  out  1  0 = CPU, 1 = debug; owner of current or last transaction
- busy  out  1  high in ACCESS and RESP

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE: sample cpu_req and dbg_req at each edge.
  - If neither request is high, stay in IDLE.
  - If one or both are high, choose a winner, latch its we/addr/wdata into internal registers, set owner, and go to ACCESS.
- ACCESS (exactly one cycle):
  - mem_addr and mem_wdata come from the latched registers.
  - mem_rd = !we and mem_wr = we. The two strobes are never high together.
  - At the edge leaving ACCESS, capture mem_rdata into the winner's rdata register (reads only) and go to RESP.
- RESP (exactly one cycle):
  - Winner's ack is high; the other ack stays low.
  - The loser's rdata register holds its old value.
  - Go to IDLE unconditionally. Requests are ignored during RESP.
- Requester rule: deassert req in the cycle after ack. A req still high at the IDLE sampling edge starts a new transaction.
- The losing requester keeps req high and is served in a later transaction. Its fields are not latched until it wins.
- Memory strobes and address are registered outputs, with no combinational path from req to mem_*.
- Reset values: state = IDLE; mem_rd, mem_wr, cpu_ack, dbg_ack, busy all 0; mem_addr, mem_wdata, cpu_rdata, dbg_rdata all 0; owner = 0; last-served = debug.

## Timing
- Request high before edge E0 while in IDLE:
  - E0: enter ACCESS; strobe high from E0 to E1.
  - E1: data captured, enter RESP; ack high from E1 to E2.
  - E2: back in IDLE.
- Minimum spacing between grants is 3 cycles (peak 1 access per 3 clocks).
- Simultaneous requests: the winner is chosen as described under Configuration.
- Reset asserted mid-transaction:
  - State goes to IDLE and all strobes and acks drop immediately (asynchronously).
  - An in-flight write may be truncated. No ack is issued.
  - Requesters must reissue after reset is released.
- A request arriving during ACCESS or RESP waits for the next IDLE edge.
- Address and data are latched at grant, so changes to the winner's inputs after the grant edge do not affect the transaction.

## Configuration
- ARB_ROUND_ROBIN_EN defined: on simultaneous requests, grant the requester that was not served last.
  - Last-served register updates at every grant; its reset value is debug, so the CPU wins the first tie.
- ARB_ROUND_ROBIN_EN undefined: fixed priority, CPU always wins ties.
  - The debug port is served only in IDLE cycles where cpu_req is low.
  - The last-served register is not implemented.

## Test plan
- Debug write then read:
  - Stimulus: dbg write of 8'hA5 to addr 5'h03, then dbg read of 5'h03.
  - Response: mem_wr for one cycle with addr 03 and data A5, dbg_ack 2 cycles after grant, dbg_rdata = 8'hA5, cpu_ack never high.
- CPU read latency:
  - Stimulus: cpu_req read of 5'h1F, memory preloaded with 8'h3C.
  - Response: mem_rd high exactly one cycle, cpu_ack in the third cycle after request, cpu_rdata = 8'h3C, owner = 0.
- Simultaneous requests held continuously:
  - Response with ARB_ROUND_ROBIN_EN: grants alternate CPU, DBG, CPU, DBG, one every 3 cycles.
  - Response without the macro: 4 consecutive CPU grants and dbg_ack never high until cpu_req drops.
- Reset mid-write:
  - Stimulus: assert rst_ low during ACCESS of a CPU write.
  - Response: mem_wr and busy go 0 immediately, no cpu_ack, state is IDLE after release, a reissued request completes normally.
- Input change after grant:
  - Stimulus: change dbg_addr from 5'h04 to 5'h09 one cycle after the grant edge.
  - Response: the access uses 5'h04.
- Strobe exclusivity: an assertion checks that mem_rd and mem_wr are never both high in any test.
